// File: rtl/axis_spi_rx.sv
// SPI mode-0 peripheral receiver: synchronises SCK/CS/MOSI into clk,
// deserialises MSB-first frames and presents each word as one AXI-Stream beat.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | CS high; waiting for a new frame (requires a trusted CS-high sample)
// RECV    | CS low; shifting in bits on each synced SCK rise
// WAIT_CS | word done, or frame in progress at reset release; ignore SCK until CS high
module axis_spi_rx #(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        SCK,
  input  logic        CS,
  input  logic        MOSI,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        overrun,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  localparam int W = SPI_DATA_WIDTH;
  localparam logic [5:0] LAST_BIT = 6'(W - 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  // Marks which synchroniser stages hold real pin samples rather than reset values.
  logic [SYNC_STAGES-1:0] ok_sync_q, ok_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [31:0]    tdata_q, tdata_d;
  logic           tvalid_q, tvalid_d;
  logic           overrun_q, overrun_d;
  logic           frame_err_q, frame_err_d;
  // Set once a genuine CS-high has been seen after reset; a frame already
  // running at reset release must not be received from its middle.
  logic           armed_q, armed_d;

  logic sck_s, cs_s, mosi_s, sync_ok, sck_rise;
  logic complete;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sync_ok  = ok_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  // Synchroniser chains and SCK edge-detect flop next values.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ok_sync_d   = {ok_sync_q[SYNC_STAGES-2:0], 1'b1};
    sck_prev_d  = sck_s;
  end

  // Synchroniser registers, reset to the idle bus levels.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      ok_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ok_sync_q   <= ok_sync_d;
      sck_prev_q  <= sck_prev_d;
    end
  end

  // Frame FSM, shift register, output register and status pulses.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    armed_d     = armed_q;
    complete    = 1'b0;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sync_ok) begin
          if (cs_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = RECV;
            shift_d = '0;
            cnt_d   = '0;
          end else begin
            state_d = WAIT_CS;
          end
        end
      end
      RECV: begin
        // CS release wins over a coincident SCK rise: the frame is over.
        if (cs_s) begin
          if (cnt_q != 6'd0) begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sck_rise) begin
          shift_d = {shift_q[W-2:0], mosi_s};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == LAST_BIT) begin
            complete = 1'b1;
            state_d  = WAIT_CS;
          end
        end
      end
      WAIT_CS: begin
        if (cs_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A word can load while the held one drains in the same cycle.
    if (complete) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d        = '0;
        tdata_d[W-1:0] = shift_d;
        tvalid_d       = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_axis_spi_rx.sv
// Bench for axis_spi_rx: a 32-bit and an 8-bit receiver share SCK/MOSI with
// separate chip selects; frames are checked against a word-level reference.
module tb_axis_spi_rx;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic sck = 1'b0, mosi = 1'b0, cs32 = 1'b1, cs8 = 1'b1, tready = 1'b1;

  logic [31:0] tdata32, tdata8;
  logic tvalid32, tvalid8, busy32, busy8, ovr32, ovr8, ferr32, ferr8;

  int checks = 0;
  int failures = 0;

  // Monitor results
  logic [31:0] q32[$], q8[$];
  int vcyc32, vcyc8, novr32, novr8, nferr32, nferr8, both_cnt, stab_cnt;
  logic hold32, hold8;
  logic [31:0] hold_data32, hold_data8;

  always #5 clk = ~clk;

  axis_spi_rx #(.SPI_DATA_WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .aresetn(aresetn), .SCK(sck), .CS(cs32), .MOSI(mosi),
    .m_axis_tdata(tdata32), .m_axis_tvalid(tvalid32), .m_axis_tready(tready),
    .busy(busy32), .overrun(ovr32), .frame_err(ferr32));

  axis_spi_rx #(.SPI_DATA_WIDTH(8), .SYNC_STAGES(3)) dut8 (
    .clk(clk), .aresetn(aresetn), .SCK(sck), .CS(cs8), .MOSI(mosi),
    .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready),
    .busy(busy8), .overrun(ovr8), .frame_err(ferr8));

  // Observe both outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (aresetn) begin
      if (tvalid32 && tready) q32.push_back(tdata32);
      if (tvalid8 && tready) q8.push_back(tdata8);
      if (tvalid32) vcyc32++;
      if (tvalid8) vcyc8++;
      if (ovr32) novr32++;
      if (ovr8) novr8++;
      if (ferr32) nferr32++;
      if (ferr8) nferr8++;
      if ((ovr32 && ferr32) || (ovr8 && ferr8)) both_cnt++;
      if (hold32 && tdata32 !== hold_data32) stab_cnt++;
      if (hold8 && tdata8 !== hold_data8) stab_cnt++;
    end
    hold32 = aresetn && tvalid32 && !tready;
    hold8  = aresetn && tvalid8 && !tready;
    hold_data32 = tdata32;
    hold_data8  = tdata8;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q32.delete(); q8.delete();
    vcyc32 = 0; vcyc8 = 0; novr32 = 0; novr8 = 0;
    nferr32 = 0; nferr8 = 0; both_cnt = 0; stab_cnt = 0;
  endtask

  // Shift n bits out MSB first: d[n-1] first. SCK half period = 2 clk.
  task automatic spi_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      tick(2);
      sck = 1'b1;
      tick(2);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input bit sel8, input logic [63:0] d, input int n);
    if (sel8) cs8 = 1'b0; else cs32 = 1'b0;
    tick(3);
    spi_bits(d, n);
    tick(2);
    if (sel8) cs8 = 1'b1; else cs32 = 1'b1;
    tick(8);
  endtask

  // Reference: a frame of n bits yields the first w bits sent, if n >= w.
  function automatic logic [31:0] ref_word(input logic [63:0] d, input int n, input int w);
    logic [63:0] t;
    logic [63:0] mask;
    t = d >> (n - w);
    mask = (64'd1 << w) - 64'd1;
    return 32'(t & mask);
  endfunction

  task automatic test_reset();
    aresetn = 1'b0;
    tick(4);
    checks++; if (tvalid32 !== 1'b0 || tvalid8 !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b/%b expected 0/0", tvalid32, tvalid8); end
    checks++; if (tdata32 !== 32'h0 || tdata8 !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h/%h expected 0/0", tdata32, tdata8); end
    checks++; if (busy32 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy32, busy8); end
    checks++; if ({ovr32, ovr8, ferr32, ferr8} !== 4'b0) begin failures++; $display("FAIL reset_pulses: got %b expected 0000", {ovr32, ovr8, ferr32, ferr8}); end
    aresetn = 1'b1;
    tick(6);
    checks++; if (busy32 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b/%b expected 0/0", busy32, busy8); end
  endtask

  task automatic test_basic32();
    logic [31:0] w;
    clear_mon();
    tready = 1'b1;
    w = 32'hA5C30F96;
    frame(1'b0, {32'h0, w}, 32);
    checks++; if (q32.size() !== 1) begin failures++; $display("FAIL basic_beats: got %0d expected 1", q32.size()); end
    else begin
      checks++; if (q32[0] !== w) begin failures++; $display("FAIL basic_data: got %h expected %h", q32[0], w); end
    end
    checks++; if (vcyc32 !== 1) begin failures++; $display("FAIL basic_valid_cycles: got %0d expected 1", vcyc32); end
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b expected 0", busy32); end
    checks++; if (nferr32 !== 0 || novr32 !== 0) begin failures++; $display("FAIL basic_pulses: got ferr=%0d ovr=%0d expected 0 0", nferr32, novr32); end
  endtask

  task automatic test_busy_timing();
    int rise_at;
    // busy must be high during a frame and drop after CS returns high
    cs32 = 1'b0;
    rise_at = -1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (busy32 && rise_at < 0) rise_at = i;
    end
    // CS low at cycle 0 -> synced after 2 -> busy one cycle later
    checks++; if (rise_at !== 2) begin failures++; $display("FAIL busy_rise: got cycle %0d expected 2", rise_at); end
    cs32 = 1'b1;
    tick(6);
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL busy_fall: got %b expected 0", busy32); end
  endtask

  task automatic test_w8_back_to_back();
    clear_mon();
    tready = 1'b1;
    frame(1'b1, 64'h5A, 8);
    frame(1'b1, 64'h81, 8);
    checks++; if (q8.size() !== 2) begin failures++; $display("FAIL w8_beats: got %0d expected 2", q8.size()); end
    else begin
      checks++; if (q8[0] !== 32'h0000005A) begin failures++; $display("FAIL w8_first: got %h expected 0000005a", q8[0]); end
      checks++; if (q8[1] !== 32'h00000081) begin failures++; $display("FAIL w8_second: got %h expected 00000081", q8[1]); end
    end
    checks++; if (q32.size() !== 0) begin failures++; $display("FAIL w8_isolation: got %0d beats on 32-bit rx expected 0", q32.size()); end
  endtask

  task automatic test_overrun();
    clear_mon();
    tready = 1'b0;
    frame(1'b0, 64'h11111111, 32);
    frame(1'b0, 64'h22222222, 32);
    checks++; if (tvalid32 !== 1'b1 || tdata32 !== 32'h11111111) begin failures++; $display("FAIL ovr_held: got v=%b d=%h expected v=1 d=11111111", tvalid32, tdata32); end
    checks++; if (novr32 !== 1) begin failures++; $display("FAIL ovr_pulses: got %0d expected 1", novr32); end
    checks++; if (stab_cnt !== 0) begin failures++; $display("FAIL ovr_stable: got %0d changes expected 0", stab_cnt); end
    tready = 1'b1;
    tick(4);
    checks++; if (q32.size() !== 1) begin failures++; $display("FAIL ovr_drain_beats: got %0d expected 1", q32.size()); end
    else begin
      checks++; if (q32[0] !== 32'h11111111) begin failures++; $display("FAIL ovr_drain_data: got %h expected 11111111", q32[0]); end
    end
    checks++; if (tvalid32 !== 1'b0) begin failures++; $display("FAIL ovr_valid_clear: got %b expected 0", tvalid32); end
  endtask

  task automatic test_frame_err();
    logic [31:0] full;
    clear_mon();
    tready = 1'b1;
    full = 32'hDEADBEEF;
    frame(1'b0, {32'h0, full} >> 19, 13);
    checks++; if (nferr32 !== 1) begin failures++; $display("FAIL ferr_pulses: got %0d expected 1", nferr32); end
    checks++; if (vcyc32 !== 0) begin failures++; $display("FAIL ferr_no_valid: got %0d cycles expected 0", vcyc32); end
    frame(1'b0, 64'h12345678, 32);
    checks++; if (q32.size() !== 1) begin failures++; $display("FAIL ferr_next_beats: got %0d expected 1", q32.size()); end
    else begin
      checks++; if (q32[0] !== 32'h12345678) begin failures++; $display("FAIL ferr_next_data: got %h expected 12345678", q32[0]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] junk;
    clear_mon();
    tready = 1'b1;
    junk = $urandom();
    cs32 = 1'b0;
    tick(3);
    spi_bits({32'h0, junk} >> 12, 20);
    aresetn = 1'b0;
    tick(2);
    checks++; if ({tvalid32, busy32, ovr32, ferr32} !== 4'b0 || tdata32 !== 32'h0) begin failures++; $display("FAIL rst_mid_outputs: got v/b/o/f=%b d=%h expected 0000 0", {tvalid32, busy32, ovr32, ferr32}, tdata32); end
    aresetn = 1'b1;
    spi_bits({32'h0, junk}, 12);
    tick(2);
    cs32 = 1'b1;
    tick(8);
    checks++; if (q32.size() !== 0 || vcyc32 !== 0) begin failures++; $display("FAIL rst_mid_no_beat: got %0d beats expected 0", q32.size()); end
    checks++; if (nferr32 !== 0) begin failures++; $display("FAIL rst_mid_no_ferr: got %0d expected 0", nferr32); end
    frame(1'b0, 64'hCAFEF00D, 32);
    checks++; if (q32.size() !== 1) begin failures++; $display("FAIL rst_next_beats: got %0d expected 1", q32.size()); end
    else begin
      checks++; if (q32[0] !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_next_data: got %h expected cafef00d", q32[0]); end
    end
  endtask

  task automatic test_overlong();
    logic [63:0] d;
    logic [31:0] exp;
    clear_mon();
    tready = 1'b1;
    d = {$urandom(), $urandom()};
    exp = ref_word(d, 40, 32);
    frame(1'b0, d, 40);
    checks++; if (q32.size() !== 1) begin failures++; $display("FAIL long_beats: got %0d expected 1", q32.size()); end
    else begin
      checks++; if (q32[0] !== exp) begin failures++; $display("FAIL long_data: got %h expected %h", q32[0], exp); end
    end
    checks++; if (nferr32 !== 0) begin failures++; $display("FAIL long_no_ferr: got %0d expected 0", nferr32); end
  endtask

  task automatic test_random();
    logic [31:0] e32[$], e8[$];
    int ef32, ef8, n, w;
    bit sel8;
    logic [63:0] d;
    clear_mon();
    tready = 1'b1;
    ef32 = 0; ef8 = 0;
    for (int k = 0; k < 14; k++) begin
      sel8 = 1'($urandom_range(0, 1));
      w = sel8 ? 8 : 32;
      case ($urandom_range(0, 3))
        0: n = w;
        1: n = $urandom_range(1, w - 1);
        2: n = w + $urandom_range(1, 8);
        default: n = 0;
      endcase
      d = {$urandom(), $urandom()};
      frame(sel8, d, n);
      if (n >= w) begin
        if (sel8) e8.push_back(ref_word(d, n, w)); else e32.push_back(ref_word(d, n, w));
      end else if (n > 0) begin
        if (sel8) ef8++; else ef32++;
      end
    end
    checks++; if (q32.size() !== e32.size() || q8.size() !== e8.size()) begin failures++; $display("FAIL rand_beat_count: got %0d/%0d expected %0d/%0d", q32.size(), q8.size(), e32.size(), e8.size()); end
    else begin
      for (int i = 0; i < e32.size(); i++) begin
        checks++; if (q32[i] !== e32[i]) begin failures++; $display("FAIL rand_data32[%0d]: got %h expected %h", i, q32[i], e32[i]); end
      end
      for (int i = 0; i < e8.size(); i++) begin
        checks++; if (q8[i] !== e8[i]) begin failures++; $display("FAIL rand_data8[%0d]: got %h expected %h", i, q8[i], e8[i]); end
      end
    end
    checks++; if (nferr32 !== ef32 || nferr8 !== ef8) begin failures++; $display("FAIL rand_ferr: got %0d/%0d expected %0d/%0d", nferr32, nferr8, ef32, ef8); end
    checks++; if (novr32 !== 0 || novr8 !== 0) begin failures++; $display("FAIL rand_ovr: got %0d/%0d expected 0/0", novr32, novr8); end
    checks++; if (vcyc32 !== e32.size() || vcyc8 !== e8.size()) begin failures++; $display("FAIL rand_valid_cycles: got %0d/%0d expected %0d/%0d", vcyc32, vcyc8, e32.size(), e8.size()); end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL rand_pulse_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    hold32 = 1'b0; hold8 = 1'b0; hold_data32 = '0; hold_data8 = '0;
    clear_mon();
    tick(1);
    test_reset();
    test_basic32();
    test_busy_timing();
    test_w8_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_midframe();
    test_overlong();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
